// File: rtl/codec_serial_intf.sv
// CS4272 serial audio port master: MCLK/SCLK/LRCLK generation, 16-bit stereo TX/RX, CODEC reset.
// Define CODEC_I2S_MODE_EN for I2S framing (one-slot delay, LRCLK low = left); default is left-justified.

module codec_serial_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        vld,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        SDin,
  input  logic        SDout,
  output logic        RSTn
);

`ifdef CODEC_I2S_MODE_EN
  localparam logic [9:0] LOAD_L   = 10'h00F;
  localparam logic [9:0] LOAD_R   = 10'h20F;
  localparam logic [9:0] RX_LATCH = 10'h108;
  localparam logic [9:0] RX_OUT   = 10'h308;
  localparam logic       LR_RST   = 1'b0;
`else
  localparam logic [9:0] LOAD_L   = 10'h3FF;
  localparam logic [9:0] LOAD_R   = 10'h1FF;
  localparam logic [9:0] RX_LATCH = 10'h0F8;
  localparam logic [9:0] RX_OUT   = 10'h2F8;
  localparam logic       LR_RST   = 1'b1;
`endif

  logic [9:0]  r_cnt;
  logic        r_lrclk;
  logic        r_rstn;
  logic [15:0] r_tx_shift;
  logic [15:0] r_rht_hold;
  logic [15:0] r_rx_shift;
  logic [15:0] r_rx_lft;
  logic [15:0] r_lft_in;
  logic [15:0] r_rht_in;
  logic        r_vld;

  logic [9:0]  w_cnt_nxt;
  logic [4:0]  w_slot;
  logic        w_rx_en;
  logic        w_lr_nxt;

  assign w_cnt_nxt = r_cnt + 10'd1;
  assign w_slot    = r_cnt[8:4];

`ifdef CODEC_I2S_MODE_EN
  assign w_rx_en  = (r_cnt[3:0] == 4'h7) && (w_slot >= 5'd1) && (w_slot <= 5'd16);
  assign w_lr_nxt = w_cnt_nxt[9];
`else
  assign w_rx_en  = (r_cnt[3:0] == 4'h7) && (w_slot < 5'd16);
  assign w_lr_nxt = ~w_cnt_nxt[9];
`endif

  // LRCLK gets its own flop, decoded from the next count, so it stays a pure register output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lrclk <= LR_RST;
      r_rstn  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_lrclk <= w_lr_nxt;
      if (r_cnt == 10'h3FF)
        r_rstn <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_rht_hold <= '0;
    end else if (r_cnt == LOAD_L) begin
      r_tx_shift <= lft_out;
      r_rht_hold <= rht_out;
    end else if (r_cnt == LOAD_R) begin
      r_tx_shift <= r_rht_hold;
    end else if (r_cnt[3:0] == 4'hF) begin
      r_tx_shift <= {r_tx_shift[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift <= '0;
      r_rx_lft   <= '0;
      r_lft_in   <= '0;
      r_rht_in   <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_rx_en)
        r_rx_shift <= {r_rx_shift[14:0], SDout};
      if (r_cnt == RX_LATCH)
        r_rx_lft <= r_rx_shift;
      if (r_cnt == RX_OUT) begin
        r_lft_in <= r_rx_lft;
        r_rht_in <= r_rx_shift;
        r_vld    <= r_rstn;
      end
    end
  end

  assign MCLK   = r_cnt[1];
  assign SCLK   = r_cnt[3];
  assign LRCLK  = r_lrclk;
  assign SDin   = r_tx_shift[15];
  assign RSTn   = r_rstn;
  assign vld    = r_vld;
  assign lft_in = r_lft_in;
  assign rht_in = r_rht_in;

endmodule

// File: tb/tb_codec_serial_intf.sv
// Loopback bench for codec_serial_intf: directed vector table plus hand sequences for
// SDin slot pattern, mid-frame input change and asynchronous reset mid-operation.

module tb_codec_serial_intf;

  logic        clk;
  logic        rst;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        vld;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;
  logic        SDout;
  logic        RSTn;

  assign SDout = SDin;

  codec_serial_intf dut (
    .clk     (clk),
    .rst     (rst),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .vld     (vld),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .SDout   (SDout),
    .RSTn    (RSTn)
  );

  // vld is registered off the latch event, so it is seen in the cycle after it
`ifdef CODEC_I2S_MODE_EN
  localparam logic [9:0]  VLD_SEEN = 10'h309;
  localparam logic [9:0]  CAP_CNT  = 10'h00F;
  localparam logic        LR_RST   = 1'b0;
  localparam logic [31:0] PAT_8001 = 32'h4000_8000;
`else
  localparam logic [9:0]  VLD_SEEN = 10'h2F9;
  localparam logic [9:0]  CAP_CNT  = 10'h3FF;
  localparam logic        LR_RST   = 1'b1;
  localparam logic [31:0] PAT_8001 = 32'h8001_0000;
`endif
  localparam int FIRST_VLD = 1024 + int'(VLD_SEEN);

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e_clk    = 0;
  int e_rstn   = 0;
  int e_vld    = 0;
  int e_sdin   = 0;
  int e_data   = 0;
  int e_rst    = 0;
  logic [15:0] m_l = '0;
  logic [15:0] m_r = '0;
  logic [9:0]  mon_c;
  logic        mon_ev;
  logic        mon_lr;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_sdin(input logic [9:0] c, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] w;
    logic [4:0]  s;
    w = c[9] ? r : l;
    s = c[8:4];
`ifdef CODEC_I2S_MODE_EN
    if (s >= 5'd1 && s <= 5'd16) return w[4'(5'd16 - s)];
`else
    if (s < 5'd16) return w[4'(5'd15 - s)];
`endif
    return 1'b0;
  endfunction

  // Spec model: cycle count since reset release and per-cycle expected outputs
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cyc = 0;
      if ({MCLK, SCLK, LRCLK, SDin, RSTn, vld} !== {1'b0, 1'b0, LR_RST, 1'b0, 1'b0, 1'b0} ||
          lft_in !== 16'h0 || rht_in !== 16'h0)
        e_rst++;
    end else begin
      cyc++;
      mon_c  = cyc[9:0];
      mon_ev = (cyc >= 1025) && (mon_c == VLD_SEEN);
`ifdef CODEC_I2S_MODE_EN
      mon_lr = mon_c[9];
`else
      mon_lr = ~mon_c[9];
`endif
      if (MCLK !== mon_c[1] || SCLK !== mon_c[3] || LRCLK !== mon_lr) e_clk++;
      if (RSTn !== (cyc >= 1024)) e_rstn++;
      if (vld !== mon_ev) e_vld++;
      if (SDin !== exp_sdin(mon_c, m_l, m_r)) e_sdin++;
      if (mon_ev && (lft_in !== m_l || rht_in !== m_r)) e_data++;
    end
  end

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_l = '0;
      m_r = '0;
    end else if (cyc[9:0] == CAP_CNT) begin
      m_l = lft_out;
      m_r = rht_out;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_vld(output int at);
    int n;
    n = 0;
    step();
    while (vld !== 1'b1 && n < 2100) begin
      step();
      n++;
    end
    chk("vld arrives", 32'(vld === 1'b1), 32'd1);
    at = cyc;
  endtask

  task automatic wait_cnt(input logic [9:0] c);
    int n;
    n = 0;
    step();
    while (cyc[9:0] != c && n < 1100) begin
      step();
      n++;
    end
    chk("reach cnt", 32'(cyc[9:0] == c), 32'd1);
  endtask

  initial begin
    int t;
    int prev;
    logic [31:0] lv;
    logic [31:0] rv;
    logic [9:0]  c;

    vecs[0] = '{16'h8001, 16'h0000, 16'h8001, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};

    rst = 1'b0;
    lft_out = '0;
    rht_out = '0;
    #1 rst = 1'b1;
    repeat (3) step();

    chk("rst MCLK",   32'(MCLK),   32'd0);
    chk("rst SCLK",   32'(SCLK),   32'd0);
    chk("rst LRCLK",  32'(LRCLK),  32'(LR_RST));
    chk("rst SDin",   32'(SDin),   32'd0);
    chk("rst RSTn",   32'(RSTn),   32'd0);
    chk("rst vld",    32'(vld),    32'd0);
    chk("rst lft_in", 32'(lft_in), 32'd0);
    chk("rst rht_in", 32'(rht_in), 32'd0);

    lft_out = 16'hA5C3;
    rht_out = 16'h5A3C;
    rst = 1'b0;
    wait_vld(t);
    chk("first vld cycle", t, FIRST_VLD);
    chk("first lft_in", 32'(lft_in), 32'h0000_A5C3);
    chk("first rht_in", 32'(rht_in), 32'h0000_5A3C);
    prev = t;
    wait_vld(t);
    chk("vld interval", t - prev, 32'd1024);
    chk("second lft_in", 32'(lft_in), 32'h0000_A5C3);
    chk("second rht_in", 32'(rht_in), 32'h0000_5A3C);

    for (int i = 0; i < 4; i++) begin
      lft_out = vecs[i].l;
      rht_out = vecs[i].r;
      prev = t;
      wait_vld(t);
      chk("vec interval", t - prev, 32'd1024);
      chk("vec lft_in", 32'(lft_in), 32'(vecs[i].el));
      chk("vec rht_in", 32'(rht_in), 32'(vecs[i].er));
      step();
      chk("vld width", 32'(vld), 32'd0);
    end

    lft_out = 16'h8001;
    rht_out = 16'h0000;
    wait_cnt(10'h000);
    lv = '0;
    rv = '0;
    for (int i = 0; i < 1024; i++) begin
      c = cyc[9:0];
      if (c[3:0] == 4'h8) begin
        if (c[9]) rv[5'd31 - c[8:4]] = SDin;
        else      lv[5'd31 - c[8:4]] = SDin;
      end
      step();
    end
    chk("SDin left slots", lv, PAT_8001);
    chk("SDin right slots", rv, 32'h0);

    lft_out = 16'h1111;
    rht_out = 16'h0000;
    wait_cnt(10'h000);
    wait_cnt(10'h100);
    lft_out = 16'h2222;
    wait_vld(t);
    chk("late change old frame", 32'(lft_in), 32'h0000_1111);
    wait_vld(t);
    chk("late change next frame", 32'(lft_in), 32'h0000_2222);

    wait_cnt(10'h150);
    chk("RSTn before reset", 32'(RSTn), 32'd1);
    chk("lft_in before reset", 32'(lft_in), 32'h0000_2222);
    rst = 1'b1;
    #1;
    chk("async RSTn",   32'(RSTn),   32'd0);
    chk("async lft_in", 32'(lft_in), 32'd0);
    chk("async SDin",   32'(SDin),   32'd0);
    chk("async vld",    32'(vld),    32'd0);
    chk("async LRCLK",  32'(LRCLK),  32'(LR_RST));
    repeat (2) step();
    rst = 1'b0;
    wait_vld(t);
    chk("vld after reset", t, FIRST_VLD);
    chk("lft_in after reset", 32'(lft_in), 32'h0000_2222);
    chk("rht_in after reset", 32'(rht_in), 32'h0000_0000);

    chk("clock waveforms", e_clk, 32'd0);
    chk("RSTn timing", e_rstn, 32'd0);
    chk("vld timing", e_vld, 32'd0);
    chk("SDin stream", e_sdin, 32'd0);
    chk("rx data at vld", e_data, 32'd0);
    chk("reset values", e_rst, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
